// File: rtl/dist_mem_bank.sv
// Multi-channel distance buffer: entries are written across all channels at once,
// then streamed out in order with a valid/ready handshake on a dump request.
module dist_mem_bank #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8,
  parameter int NUM_CH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [NUM_CH*WIDTH-1:0]  wr_data,
  output logic                     wr_ready,
  input  logic                     dump_start,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*WIDTH-1:0]  out_data,
  output logic [ADDR_WIDTH-1:0]    out_addr,
  output logic [ADDR_WIDTH:0]      count,
  output logic                     full,
  output logic                     dump_done
);

  typedef enum logic [1:0] {IDLE, PREFETCH, DUMP, DONE} state_e;

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   ONE_W   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

  state_e                    state_q;
  logic [ADDR_WIDTH:0]       count_q;
  logic [ADDR_WIDTH:0]       wr_ptr_q;
  logic [ADDR_WIDTH-1:0]     rd_ptr_q;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic                      out_valid_q;
  logic                      dump_done_q;
  logic [NUM_CH*WIDTH-1:0]   out_data_q;
  logic [NUM_CH*WIDTH-1:0]   rd_word;
  logic                      wr_fire;
  logic                      out_fire;
  logic                      last_entry;

  assign full       = (count_q == DEPTH_C);
  assign wr_ready   = (state_q == IDLE) && !full;
  assign wr_fire    = wr_valid && wr_ready;
  assign out_fire   = out_valid_q && out_ready;
  assign last_entry = (({1'b0, rd_ptr_q} + ONE_W) == count_q);

  // In DUMP the next entry is fetched ahead so a handshake causes no bubble.
  assign rd_addr = (state_q == DUMP) ? rd_ptr_q + ONE_A : rd_ptr_q;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_fire) begin
        mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data[ch*WIDTH +: WIDTH];
      end
    end

    assign rd_word[ch*WIDTH +: WIDTH] = mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      dump_done_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      dump_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_fire) begin
            wr_ptr_q <= wr_ptr_q + ONE_W;
            count_q  <= count_q + ONE_W;
          end
          // A write accepted in the same cycle counts toward the dump.
          if (dump_start) begin
            if (count_q != '0 || wr_fire) begin
              state_q  <= PREFETCH;
              rd_ptr_q <= '0;
            end else begin
              state_q     <= DONE;
              dump_done_q <= 1'b1;
            end
          end
        end
        PREFETCH: begin
          out_data_q  <= rd_word;
          out_valid_q <= 1'b1;
          state_q     <= DUMP;
        end
        DUMP: begin
          if (out_fire) begin
            if (last_entry) begin
              out_valid_q <= 1'b0;
              dump_done_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              rd_ptr_q   <= rd_ptr_q + ONE_A;
              out_data_q <= rd_word;
            end
          end
        end
        DONE: begin
          count_q  <= '0;
          wr_ptr_q <= '0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = rd_ptr_q;
  assign count     = count_q;
  assign dump_done = dump_done_q;

endmodule
